// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Resolves data-memory
// wait, taken-branch and load-use hazards, owns the data-memory request, and
// keeps saturating stall/flush counters plus a sticky memory-timeout flag.
//
// Data-memory handshake: dmem_req is high whenever the instruction in MEM is a
// load or store. An access completes on the rising edge of a cycle where both
// dmem_req and dmem_ack are high. Until then the request stays asserted, because
// the frozen EX/MEM register keeps MEM_ld/MEM_str stable.
module pipeline_hazard_ctrl #(
   parameter int XLEN     = 32,
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic [4:0]       EX_rd,
   input  logic             EX_we,
   input  logic             EX_ld,
   input  logic             EX_taken,
   input  logic             MEM_ld,
   input  logic             MEM_str,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_err,
   output logic             dbg_state_o
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   // Reject parameter sets the timeout logic cannot honour.
   generate
      if (MAX_WAIT < 2 || XLEN < 1) begin : g_param_check
         $error("pipeline_hazard_ctrl: MAX_WAIT must be >= 2 and XLEN >= 1");
      end
   endgenerate

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              mem_err_q, mem_err_d;

   logic memop;
   logic mem_stall;
   logic load_use;

   assign memop     = MEM_ld | MEM_str;
   assign mem_stall = memop & ~dmem_ack;
   assign load_use  = EX_ld & EX_we & (EX_rd != 5'd0) &
                      ((ID_use_rs1 & (ID_rs1 == EX_rd)) |
                       (ID_use_rs2 & (ID_rs2 == EX_rd)));

   // Control outputs: memory stall beats taken branch beats load-use; all held low in reset.
   always_comb begin
      dmem_req      = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      if (rst) begin
         dmem_req  = memop;
         mem_wb_en = 1'b1;
         if (mem_stall) begin
            // Freeze PC..EX/MEM; MEM/WB drains a bubble while memory is busy.
            mem_wb_bubble = 1'b1;
         end else begin
            ex_mem_en = 1'b1;
            id_ex_en  = 1'b1;
            if (EX_taken) begin
               // Squash both younger instructions; the ID one cannot cause a load-use.
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               // Hold PC and IF/ID one cycle, inject a bubble into ID/EX.
               id_ex_flush = 1'b1;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
            end
         end
      end
   end

   // Next-state values for the FSM, wait timer, sticky error and saturating counters.
   always_comb begin
      state_d     = mem_stall ? MEM_WAIT : RUN;
      wait_cnt_d  = '0;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == MEM_WAIT && mem_stall) begin
         if (wait_cnt_q >= WAIT_LAST) begin
            mem_err_d = 1'b1;
         end
         if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
         end else begin
            wait_cnt_d = wait_cnt_q;
         end
      end
      if (!pc_en && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && flush_cnt_q != '1) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // FSM state and its registered outputs (counters, timeout flag).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign mem_err     = mem_err_q;
   assign dbg_state_o = (state_q == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (16-bit counters / MAX_WAIT=16
// and 2-bit counters / MAX_WAIT=4) share one stimulus stream. Directed scenario
// tasks check hand-derived values; a random phase checks against a reference model.
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] ID_rs1, ID_rs2, EX_rd;
   logic       ID_use_rs1, ID_use_rs2, EX_we, EX_ld, EX_taken;
   logic       MEM_ld, MEM_str, dmem_ack;

   logic        dmem_req_a, pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
   logic        if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a, mem_err_a, dbg_a;
   logic [15:0] stall_cnt_a, flush_cnt_a;
   logic        dmem_req_b, pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
   logic        if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b, mem_err_b, dbg_b;
   logic [1:0]  stall_cnt_b, flush_cnt_b;

   // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
   logic [8:0] obs_a, obs_b;
   assign obs_a = {dmem_req_a, pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                   if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a};
   assign obs_b = {dmem_req_b, pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                   if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b};

   int errors = 0;
   int checks = 0;

   pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(16), .MAX_WAIT(16)) u_a (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_we(EX_we),
      .EX_ld(EX_ld), .EX_taken(EX_taken), .MEM_ld(MEM_ld), .MEM_str(MEM_str),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req_a), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
      .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
      .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
      .mem_wb_bubble(mem_wb_bubble_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a),
      .mem_err(mem_err_a), .dbg_state_o(dbg_a));

   pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(2), .MAX_WAIT(4)) u_b (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_we(EX_we),
      .EX_ld(EX_ld), .EX_taken(EX_taken), .MEM_ld(MEM_ld), .MEM_str(MEM_str),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req_b), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
      .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
      .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
      .mem_wb_bubble(mem_wb_bubble_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b),
      .mem_err(mem_err_b), .dbg_state_o(dbg_b));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: expected control word from the hazard priority rules.
   function automatic logic [8:0] exp_ctrl();
      logic [7:0] act;
      logic       memop, lu;
      if (!rst) return 9'd0;
      memop = MEM_ld | MEM_str;
      lu = EX_ld && EX_we && (EX_rd != 5'd0) &&
           ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
      if (memop && !dmem_ack) act = 8'b0000_1001;
      else if (EX_taken)      act = 8'b1111_1110;
      else if (lu)            act = 8'b0011_1010;
      else                    act = 8'b1111_1000;
      return {memop, act};
   endfunction

   // Reference model state: waiting flag, consecutive wait edges, sticky errors, counters.
   bit m_wait, m_err_a, m_err_b;
   int m_edges, m_stall_a, m_stall_b, m_flush_a, m_flush_b;

   always @(posedge clk or negedge rst) begin : model
      logic [8:0] e;
      bit         stall;
      if (!rst) begin
         m_wait = 0; m_edges = 0; m_err_a = 0; m_err_b = 0;
         m_stall_a = 0; m_stall_b = 0; m_flush_a = 0; m_flush_b = 0;
      end else begin
         e = exp_ctrl();
         stall = (MEM_ld || MEM_str) && !dmem_ack;
         if (m_wait && stall) begin
            m_edges = m_edges + 1;
            if (m_edges >= 16) m_err_a = 1;
            if (m_edges >= 4)  m_err_b = 1;
         end else begin
            m_edges = 0;
         end
         m_wait = stall;
         if (!e[7]) begin
            if (m_stall_a < 65535) m_stall_a++;
            if (m_stall_b < 3)     m_stall_b++;
         end
         if (e[2]) begin
            if (m_flush_a < 65535) m_flush_a++;
            if (m_flush_b < 3)     m_flush_b++;
         end
      end
   end

   // Driver tasks
   task automatic set_idle();
      ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0;
      ID_use_rs1 = 0; ID_use_rs2 = 0; EX_we = 0; EX_ld = 0; EX_taken = 0;
      MEM_ld = 0; MEM_str = 0; dmem_ack = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drive_load_use(input logic [4:0] rd);
      EX_ld = 1; EX_we = 1; EX_rd = rd;
      ID_rs1 = 7; ID_use_rs1 = 1; ID_rs2 = rd; ID_use_rs2 = 1;
   endtask

   // Scenario tasks
   task automatic test_reset();
      rst = 1'b0;
      set_idle();
      MEM_ld = 1; EX_taken = 1; drive_load_use(5'd3);
      @(negedge clk); #1;
      checks++;
      if (obs_a !== 9'd0 || obs_b !== 9'd0) begin
         errors++; $display("FAIL reset_outputs: got %b/%b want 0", obs_a, obs_b);
      end
      checks++;
      if ({stall_cnt_a, flush_cnt_a, mem_err_a, dbg_a} !== 34'd0) begin
         errors++; $display("FAIL reset_state_a: got %0d %0d %b %b want 0 0 0 0",
                             stall_cnt_a, flush_cnt_a, mem_err_a, dbg_a);
      end
      set_idle();
      rst = 1'b1; #1;
      checks++;
      if (obs_a !== 9'b011111000) begin
         errors++; $display("FAIL reset_release_ctrl: got %b want 011111000", obs_a);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive_load_use(5'd5); #1;
      checks++;
      if (obs_a !== 9'b000111010 || obs_b !== 9'b000111010) begin
         errors++; $display("FAIL load_use_ctrl: got %b/%b want 000111010", obs_a, obs_b);
      end
      @(negedge clk);
      set_idle(); MEM_ld = 1; dmem_ack = 1; #1;
      checks++;
      if (obs_a !== 9'b111111000 || stall_cnt_a !== 16'd1) begin
         errors++; $display("FAIL load_use_release: got %b cnt=%0d want 111111000 cnt=1",
                             obs_a, stall_cnt_a);
      end
      @(negedge clk); set_idle(); #1;
      checks++;
      if (stall_cnt_a !== 16'd1 || dbg_a !== 1'b0) begin
         errors++; $display("FAIL single_cycle_ack: got cnt=%0d st=%b want cnt=1 st=0",
                             stall_cnt_a, dbg_a);
      end
      // Destination x0 never creates a hazard
      do_reset();
      drive_load_use(5'd0); #1;
      checks++;
      if (obs_a !== 9'b011111000) begin
         errors++; $display("FAIL load_use_x0_ctrl: got %b want 011111000", obs_a);
      end
      @(negedge clk); set_idle(); #1;
      checks++;
      if (stall_cnt_a !== 16'd0) begin
         errors++; $display("FAIL load_use_x0_cnt: got %0d want 0", stall_cnt_a);
      end
      // Matching rs1 that is not actually read is not a hazard; once read it is
      EX_ld = 1; EX_we = 1; EX_rd = 9; ID_rs1 = 9; ID_use_rs1 = 0; ID_rs2 = 3; ID_use_rs2 = 1; #1;
      checks++;
      if (obs_a !== 9'b011111000) begin
         errors++; $display("FAIL unused_rs1: got %b want 011111000", obs_a);
      end
      ID_use_rs1 = 1; #1;
      checks++;
      if (obs_a !== 9'b000111010) begin
         errors++; $display("FAIL used_rs1: got %b want 000111010", obs_a);
      end
      EX_we = 0; #1;
      checks++;
      if (obs_a !== 9'b011111000) begin
         errors++; $display("FAIL load_no_we: got %b want 011111000", obs_a);
      end
   endtask

   task automatic test_branch_load_use();
      do_reset();
      drive_load_use(5'd5); EX_taken = 1; #1;
      checks++;
      if (obs_a !== 9'b011111110 || obs_b !== 9'b011111110) begin
         errors++; $display("FAIL branch_ctrl: got %b/%b want 011111110", obs_a, obs_b);
      end
      @(negedge clk); set_idle(); #1;
      checks++;
      if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0 || flush_cnt_b !== 2'd1) begin
         errors++; $display("FAIL branch_counts: got f=%0d s=%0d fb=%0d want 1 0 1",
                             flush_cnt_a, stall_cnt_a, flush_cnt_b);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      MEM_ld = 1; dmem_ack = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (obs_a !== 9'b100001001 || dbg_a !== (i != 0)) begin
            errors++; $display("FAIL mem_wait_cycle%0d: got %b st=%b want 100001001 st=%b",
                                i, obs_a, dbg_a, (i != 0));
         end
         @(negedge clk);
      end
      dmem_ack = 1; #1;
      checks++;
      if (obs_a !== 9'b111111000 || dbg_a !== 1'b1) begin
         errors++; $display("FAIL mem_wait_ack: got %b st=%b want 111111000 st=1", obs_a, dbg_a);
      end
      @(negedge clk); set_idle(); #1;
      checks++;
      if (dbg_a !== 1'b0 || stall_cnt_a !== 16'd3 || stall_cnt_b !== 2'd3 || mem_err_b !== 1'b0) begin
         errors++; $display("FAIL mem_wait_after: got st=%b s=%0d sb=%0d eb=%b want 0 3 3 0",
                             dbg_a, stall_cnt_a, stall_cnt_b, mem_err_b);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      MEM_str = 1; dmem_ack = 0;
      for (int e = 1; e <= 18; e++) begin
         @(negedge clk); #1;
         checks++;
         if (mem_err_b !== (e >= 5) || mem_err_a !== (e >= 17) || obs_a !== 9'b100001001) begin
            errors++; $display("FAIL timeout_edge%0d: got eb=%b ea=%b ctrl=%b want %b %b 100001001",
                                e, mem_err_b, mem_err_a, obs_a, (e >= 5), (e >= 17));
         end
      end
      dmem_ack = 1;
      @(negedge clk); set_idle(); #1;
      checks++;
      if ({mem_err_a, mem_err_b, dbg_a} !== 3'b110 || stall_cnt_a !== 16'd18 || stall_cnt_b !== 2'd3) begin
         errors++; $display("FAIL timeout_sticky: got ea=%b eb=%b st=%b s=%0d sb=%0d want 1 1 0 18 3",
                             mem_err_a, mem_err_b, dbg_a, stall_cnt_a, stall_cnt_b);
      end
      do_reset(); #1;
      checks++;
      if (mem_err_a !== 1'b0 || mem_err_b !== 1'b0) begin
         errors++; $display("FAIL timeout_clear: got %b %b want 0 0", mem_err_a, mem_err_b);
      end
   endtask

   task automatic test_priority();
      do_reset();
      MEM_ld = 1; dmem_ack = 0; EX_taken = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (obs_a !== 9'b100001001) begin
            errors++; $display("FAIL priority_stall%0d: got %b want 100001001", i, obs_a);
         end
         @(negedge clk); #1;
         checks++;
         if (flush_cnt_a !== 16'd0) begin
            errors++; $display("FAIL priority_flush_cnt%0d: got %0d want 0", i, flush_cnt_a);
         end
      end
      dmem_ack = 1; #1;
      checks++;
      if (obs_a !== 9'b111111110) begin
         errors++; $display("FAIL priority_release: got %b want 111111110", obs_a);
      end
      @(negedge clk); set_idle(); #1;
      checks++;
      if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd2) begin
         errors++; $display("FAIL priority_counts: got f=%0d s=%0d want 1 2", flush_cnt_a, stall_cnt_a);
      end
   endtask

   task automatic test_saturation_reset();
      do_reset();
      drive_load_use(5'd12);
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (stall_cnt_b !== 2'd3 || stall_cnt_a !== 16'd5) begin
         errors++; $display("FAIL saturation: got sb=%0d s=%0d want 3 5", stall_cnt_b, stall_cnt_a);
      end
      set_idle(); MEM_ld = 1; dmem_ack = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (dbg_a !== 1'b1) begin
         errors++; $display("FAIL midwait_state: got %b want 1", dbg_a);
      end
      rst = 1'b0; #1;
      checks++;
      if (obs_a !== 9'd0 || obs_b !== 9'd0 || {dbg_a, dbg_b} !== 2'b00) begin
         errors++; $display("FAIL midwait_reset_outputs: got %b/%b st=%b%b want 0", obs_a, obs_b, dbg_a, dbg_b);
      end
      checks++;
      if ({stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b} !== 36'd0) begin
         errors++; $display("FAIL midwait_reset_counters: got %0d %0d %0d %0d want 0",
                             stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b);
      end
      @(negedge clk); set_idle(); rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (dbg_a !== 1'b0 || stall_cnt_a !== 16'd0 || obs_a !== 9'b011111000) begin
         errors++; $display("FAIL after_reset_run: got st=%b s=%0d ctrl=%b want 0 0 011111000",
                             dbg_a, stall_cnt_a, obs_a);
      end
   endtask

   task automatic test_random();
      logic [8:0] e;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 63) != 0);
         ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
         EX_rd = 5'($urandom_range(0, 3));
         ID_use_rs1 = 1'($urandom_range(0, 1)); ID_use_rs2 = 1'($urandom_range(0, 1));
         EX_we = ($urandom_range(0, 3) != 0); EX_ld = ($urandom_range(0, 1) != 0);
         EX_taken = ($urandom_range(0, 3) == 0);
         if (!m_wait || $urandom_range(0, 15) == 0) begin
            MEM_ld = ($urandom_range(0, 2) == 0); MEM_str = ($urandom_range(0, 4) == 0);
         end
         dmem_ack = ($urandom_range(0, 3) == 0);
         #1;
         e = exp_ctrl();
         checks++;
         if (obs_a !== e || obs_b !== e) begin
            errors++; $display("FAIL rand_ctrl[%0d]: got %b/%b want %b", n, obs_a, obs_b, e);
         end
         checks++;
         if (stall_cnt_a !== 16'(m_stall_a) || flush_cnt_a !== 16'(m_flush_a) ||
             stall_cnt_b !== 2'(m_stall_b) || flush_cnt_b !== 2'(m_flush_b)) begin
            errors++; $display("FAIL rand_cnt[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", n,
                                stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b,
                                m_stall_a, m_flush_a, m_stall_b, m_flush_b);
         end
         checks++;
         if (mem_err_a !== m_err_a || mem_err_b !== m_err_b || dbg_a !== m_wait || dbg_b !== m_wait) begin
            errors++; $display("FAIL rand_state[%0d]: got ea=%b eb=%b st=%b%b want %b %b %b", n,
                                mem_err_a, mem_err_b, dbg_a, dbg_b, m_err_a, m_err_b, m_wait);
         end
         @(negedge clk);
      end
      rst = 1'b1;
   endtask

   // Watchdog so a broken run still terminates.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch_load_use();
      test_mem_wait();
      test_timeout();
      test_priority();
      test_saturation_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
